// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: walks a PC through instruction ROM, following
// BNE/BGT branches and stopping on the halt opcode, with a saturating RUN-cycle counter.
module instr_fetch #(
    parameter int          PC_W    = 10,
    parameter int          INSTR_W = 9,
    parameter logic [3:0]  HALT_OP = 4'b1111
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [PC_W-1:0]    StartAddr,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic               TakeBranch,
    input  logic [PC_W-1:0]    BranchTarget,
    input  logic               Stall,
    output logic [PC_W-1:0]    InstrAddr,
    output logic [INSTR_W-1:0] InstrOut,
    output logic               InstrValid,
    output logic               Busy,
    output logic               Done,
    output logic [15:0]        CycleCount
);

    localparam logic [3:0] OP_BNE = 4'b0101;
    localparam logic [3:0] OP_BGT = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PC_W-1:0]   pc_r, pc_s;
    logic [15:0]       cnt_r, cnt_s;
    logic [3:0]        opcode_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc = 16'hFFFF;
        end else begin
            sat_inc = v + 16'd1;
        end
    endfunction

    assign opcode_s = InstrIn[INSTR_W-1 -: 4];

    // Next-state, next-PC and next-count decode
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE, HALT: begin
                if (Start) begin
                    state_s = RUN;
                    pc_s    = StartAddr;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                // Every RUN cycle counts, stalled or halting included.
                cnt_s = sat_inc(cnt_r);
                if (Stall) begin
                    pc_s = pc_r;
                end else if (opcode_s == HALT_OP) begin
                    state_s = HALT;
                end else if (((opcode_s == OP_BNE) || (opcode_s == OP_BGT)) && TakeBranch) begin
                    pc_s = BranchTarget;
                end else begin
                    pc_s = pc_r + PC_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                pc_s    = {PC_W{1'b0}};
                cnt_s   = 16'd0;
            end
        endcase
    end

    // State, PC and cycle-counter registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            pc_r    <= {PC_W{1'b0}};
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            cnt_r   <= cnt_s;
        end
    end

    assign InstrAddr  = pc_r;
    assign InstrValid = (state_r == RUN);
    assign Busy       = (state_r == RUN);
    assign Done       = (state_r == HALT);
    assign CycleCount = cnt_r;
    assign InstrOut   = (state_r == RUN) ? InstrIn : {INSTR_W{1'b0}};

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed per-cycle stimulus pushes hand-computed
// expectations; a negedge monitor pops and compares them against the outputs.
module tb_instr_fetch;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [9:0]  StartAddr;
    logic [8:0]  InstrIn;
    logic        TakeBranch;
    logic [9:0]  BranchTarget;
    logic        Stall;
    logic [9:0]  InstrAddr;
    logic [8:0]  InstrOut;
    logic        InstrValid;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;

    logic [8:0]  rom  [0:1023];
    logic [9:0]  btab [0:15];

    typedef struct {
        logic [9:0]  addr;
        logic        valid;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    localparam logic [8:0] I_ADD  = {4'b0000, 1'b0, 4'd1};
    localparam logic [8:0] I_XOR  = {4'b0011, 1'b0, 4'd3};
    localparam logic [8:0] I_BNE  = {4'b0101, 1'b1, 4'd3};
    localparam logic [8:0] I_BGT  = {4'b1101, 1'b1, 4'd5};
    localparam logic [8:0] I_HALT = {4'b1111, 1'b0, 4'd0};

    instr_fetch #(.PC_W(10), .INSTR_W(9), .HALT_OP(4'b1111)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .InstrIn(InstrIn), .TakeBranch(TakeBranch), .BranchTarget(BranchTarget),
        .Stall(Stall), .InstrAddr(InstrAddr), .InstrOut(InstrOut),
        .InstrValid(InstrValid), .Busy(Busy), .Done(Done), .CycleCount(CycleCount)
    );

    assign InstrIn      = rom[InstrAddr];
    assign BranchTarget = btab[InstrOut[3:0]];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endfunction

    // Monitor: compare outputs at every negedge for which an expectation is queued
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("addr",  32'(InstrAddr),  32'(e.addr));
            chk("valid", 32'(InstrValid), 32'(e.valid));
            chk("busy",  32'(Busy),       32'(e.valid));
            chk("done",  32'(Done),       32'(e.done));
            chk("count", 32'(CycleCount), 32'(e.cnt));
            chk("instr", 32'(InstrOut),   e.valid ? 32'(rom[e.addr]) : 32'd0);
        end
    end

    // Drive one cycle of inputs and queue the expected outputs after the next posedge
    task automatic cyc(input logic rst, input logic st, input logic [9:0] sa,
                       input logic tkb, input logic stl,
                       input logic [9:0] ea, input logic ev, input logic ed,
                       input logic [15:0] ec);
        exp_t e;
        @(negedge Clk);
        #1;
        Reset      = rst;
        Start      = st;
        StartAddr  = sa;
        TakeBranch = tkb;
        Stall      = stl;
        e.addr = ea; e.valid = ev; e.done = ed; e.cnt = ec;
        q.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset = 1'b1; Start = 1'b0; StartAddr = 10'd0; TakeBranch = 1'b0; Stall = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = I_ADD;
        for (int i = 0; i < 16; i++) btab[i] = 10'd0;
        btab[3] = 10'd40;
        btab[5] = 10'd100;
        rom[7] = I_HALT; rom[10] = I_BNE; rom[11] = I_HALT; rom[40] = I_HALT;
        rom[100] = I_HALT; rom[20] = I_HALT; rom[0] = I_HALT; rom[53] = I_HALT;
        rom[66] = I_HALT; rom[2] = I_HALT; rom[200] = I_HALT;

        // reset state, held with Start asserted
        cyc(1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0);
        cyc(1'b1, 1'b1, 10'd9, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd9, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 16'd0);

        // ADD, ADD, HALT at 5..7
        cyc(1'b0, 1'b1, 10'd5, 1'b0, 1'b0, 10'd5, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd6, 1'b1, 1'b0, 16'd1);
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd7, 1'b1, 1'b0, 16'd2);
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd7, 1'b0, 1'b1, 16'd3);
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd7, 1'b0, 1'b1, 16'd3);

        // BNE taken / not taken
        cyc(1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 10'd10, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd40, 1'b1, 1'b0, 16'd1);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd40, 1'b0, 1'b1, 16'd2);
        cyc(1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 10'd10, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd11, 1'b1, 1'b0, 16'd1);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd11, 1'b0, 1'b1, 16'd2);

        // XOR ignores TakeBranch
        rom[10] = I_XOR;
        cyc(1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 10'd10, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd11, 1'b1, 1'b0, 16'd1);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd11, 1'b0, 1'b1, 16'd2);

        // BGT taken
        rom[10] = I_BGT;
        cyc(1'b0, 1'b1, 10'd10, 1'b0, 1'b0, 10'd10,  1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0,  1'b1, 1'b0, 10'd100, 1'b1, 1'b0, 16'd1);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd100, 1'b0, 1'b1, 16'd2);

        // stalled HALT at 20: no halt until Stall drops
        cyc(1'b0, 1'b1, 10'd20, 1'b0, 1'b0, 10'd20, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0,  1'b1, 1'b1, 10'd20, 1'b1, 1'b0, 16'd1);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b1, 10'd20, 1'b1, 1'b0, 16'd2);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b1, 10'd20, 1'b1, 1'b0, 16'd3);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd20, 1'b0, 1'b1, 16'd4);

        // PC wrap 1023 -> 0
        cyc(1'b0, 1'b1, 10'd1023, 1'b0, 1'b0, 10'd1023, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 10'd0,    1'b1, 1'b0, 16'd1);
        cyc(1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 10'd0,    1'b0, 1'b1, 16'd2);

        // reset mid-RUN at 50, then restart with an ignored Start in RUN
        cyc(1'b0, 1'b1, 10'd50, 1'b0, 1'b0, 10'd50, 1'b1, 1'b0, 16'd0);
        cyc(1'b1, 1'b0, 10'd0,  1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 10'd50, 1'b0, 1'b0, 10'd50, 1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b1, 10'd5,  1'b0, 1'b0, 10'd51, 1'b1, 1'b0, 16'd1);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd52, 1'b1, 1'b0, 16'd2);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd53, 1'b1, 1'b0, 16'd3);
        cyc(1'b0, 1'b0, 10'd0,  1'b0, 1'b0, 10'd53, 1'b0, 1'b1, 16'd4);

        // reach HALT with CycleCount=7, then restart at 2
        cyc(1'b0, 1'b1, 10'd60, 1'b0, 1'b0, 10'd60, 1'b1, 1'b0, 16'd0);
        for (int k = 1; k <= 6; k++)
            cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'(60 + k), 1'b1, 1'b0, 16'(k));
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd66, 1'b0, 1'b1, 16'd7);
        cyc(1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 10'd2,  1'b1, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd2,  1'b0, 1'b1, 16'd1);
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd2,  1'b0, 1'b1, 16'd1);

        // saturation: long stall on a HALT, count pins at FFFF
        cyc(1'b0, 1'b1, 10'd200, 1'b0, 1'b0, 10'd200, 1'b1, 1'b0, 16'd0);
        for (int k = 1; k <= 65540; k++)
            cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 10'd200, 1'b1, 1'b0,
                (k > 65535) ? 16'hFFFF : 16'(k));
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd200, 1'b0, 1'b1, 16'hFFFF);
        cyc(1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 10'd200, 1'b0, 1'b1, 16'hFFFF);

        repeat (2) @(negedge Clk);
        #1;
        chk("drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
